// File: rtl/cla_share_pkg.sv
// Shared defaults and helpers for the shared carry-lookahead adder arbiter.
package cla_share_pkg;

    localparam int unsigned N_DEFAULT    = 32;
    localparam int unsigned NREQ_DEFAULT = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_share_arbiter_if.sv
// Request (per-requester valid/ready + operands) and response channel bundle.
interface cla_share_arbiter_if
    import cla_share_pkg::*;
#(
    parameter int unsigned N    = N_DEFAULT,
    parameter int unsigned NREQ = NREQ_DEFAULT
);
    localparam int unsigned IDW = id_width(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [N-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
    );

endinterface

// File: rtl/carry_lookahead_adder.sv
// N-bit adder built from generate/propagate terms; sum = a + b + cin, cout = carry out of bit N-1.
module carry_lookahead_adder #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum  = p ^ c[N-1:0];
    assign cout = c[N];

endmodule

// File: rtl/cla_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr (wrapping) wins when en is high.
module rr_arbiter
    import cla_share_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    localparam int unsigned IDW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/cla_share_arbiter.sv
// One carry-lookahead adder shared by NREQ requesters; round-robin grant, single registered response slot.
module cla_share_arbiter
    import cla_share_pkg::*;
#(
    parameter int unsigned N    = N_DEFAULT,
    parameter int unsigned NREQ = NREQ_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    cla_share_arbiter_if.slave bus
);
    localparam int unsigned IDW = id_width(NREQ);

    rsp_state_e     state;
    rsp_state_e     state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_idx;
    logic           grant_en;
    logic           xfer;
    logic [N-1:0]   a_sel;
    logic [N-1:0]   b_sel;
    logic           cin_sel;
    logic [N-1:0]   sum;
    logic           cout;
    logic [N-1:0]   sum_q;
    logic           cout_q;
    logic [IDW-1:0] id_q;

    // Slot can be refilled in the same cycle it drains.
    assign grant_en = !rst && ((state == EMPTY) || bus.rsp_ready);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
        .en      (grant_en),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign xfer = |gnt;

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                a_sel   = bus.req_a[i*N +: N];
                b_sel   = bus.req_b[i*N +: N];
                cin_sel = bus.req_cin[i];
            end
        end
    end

    carry_lookahead_adder #(.N(N)) u_add (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (cin_sel),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_nxt = state;
        ptr_nxt   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        if (xfer) begin
            state_nxt = FULL;
        end else if ((state == FULL) && bus.rsp_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            ptr    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            id_q   <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                sum_q  <= sum;
                cout_q <= cout;
                id_q   <= gnt_idx;
                ptr    <= ptr_nxt;
            end
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = (state == FULL);
    assign bus.busy      = (state == FULL);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_id    = id_q;

endmodule
